prll_bs_terminal_fifo: RTL and testbench

//  Terminal-side agent for one port of the parallel bus generator/arbiter.
//  It is the FIFO the bus pops from and pushes into. Local user logic feeds a
//  TX FIFO, which is exposed to the bus as pndng/D_pop/pop. Bus deliveries on

---
 rtl/prll_bs_terminal_fifo.sv | 232 +++++++++++++++++++++++
 tb/tb_prll_bs_terminal_fifo.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prll_bs_terminal_fifo.sv
`default_nettype none
// ============================================================================
// Module   : prll_bs_terminal_fifo
// Purpose  : Terminal-side agent for one port of the parallel bus
//            generator/arbiter. Local user logic fills a TX FIFO that the bus
//            drains through pndng/D_pop/pop. Words the bus delivers on
//            push/D_push go through an address filter into an RX FIFO that
//            local logic drains. Both FIFOs are first-word fall-through.
//
// Ports    : clk            clock, rising edge
//            reset          asynchronous active-low reset
//            tx_valid/tx_data/tx_ready/tx_count   user side of TX FIFO
//            pndng/D_pop/pop                      bus side of TX FIFO
//            push/D_push                          bus delivery into RX
//            rx_valid/rx_data/rx_ready/rx_count   user side of RX FIFO
//            rx_miss_cnt    misaddressed pushes dropped (saturating)
//            rx_ovf_cnt     addressed pushes dropped on RX full (saturating)
//            err_pop_empty  sticky flag, pop seen with TX FIFO empty
//
// Word     : [BITS-1:BITS-8] target, [BITS-9:BITS-16] source,
//            [BITS-17:0] payload
//
// Revision : 1.0  initial release
// ============================================================================
module prll_bs_terminal_fifo #(
    parameter int         BITS      = 32,
    parameter int         DEPTH     = 16,
    parameter logic [7:0] ID        = 8'h00,
    parameter logic [7:0] BROADCAST = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,

    // User side, TX
    input  logic                       tx_valid,
    input  logic [BITS-1:0]            tx_data,
    output logic                       tx_ready,
    output logic [$clog2(DEPTH):0]     tx_count,

    // Bus side, TX
    output logic                       pndng,
    output logic [BITS-1:0]            D_pop,
    input  logic                       pop,

    // Bus side, RX
    input  logic                       push,
    input  logic [BITS-1:0]            D_push,

    // User side, RX
    output logic                       rx_valid,
    output logic [BITS-1:0]            rx_data,
    input  logic                       rx_ready,
    output logic [$clog2(DEPTH):0]     rx_count,

    // Status
    output logic [15:0]                rx_miss_cnt,
    output logic [15:0]                rx_ovf_cnt,
    output logic                       err_pop_empty
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int            c_AW      = $clog2(DEPTH);   // index width
    localparam int            c_PW      = c_AW + 1;        // pointer width incl. wrap bit
    localparam logic [c_PW-1:0] c_PTR_ONE = c_PW'(1);
    localparam logic [15:0]   c_CNT_MAX = 16'hFFFF;

    // ------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------------
    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("prll_bs_terminal_fifo: DEPTH must be a power of 2 and >= 2");
        end
        if (BITS < 17) begin : g_bad_bits
            $error("prll_bs_terminal_fifo: BITS must leave room for target, source and payload");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [BITS-1:0] tx_mem_q [DEPTH];
    logic [BITS-1:0] rx_mem_q [DEPTH];

    logic [c_PW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [c_PW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [c_PW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [c_PW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;

    logic [15:0]     rx_miss_cnt_q, rx_miss_cnt_d;
    logic [15:0]     rx_ovf_cnt_q,  rx_ovf_cnt_d;
    logic            err_pop_empty_q, err_pop_empty_d;

    // ------------------------------------------------------------------------
    // Combinational status / control
    // ------------------------------------------------------------------------
    logic            w_tx_empty;
    logic            w_tx_full;
    logic            w_tx_wr_en;
    logic            w_tx_rd_en;
    logic [BITS-1:0] w_tx_word;

    logic            w_rx_empty;
    logic            w_rx_full;
    logic [7:0]      w_rx_addr;
    logic            w_rx_hit;
    logic            w_rx_wr_en;
    logic            w_rx_rd_en;
    logic            w_rx_ovf;
    logic            w_rx_miss;

    // Source field of the user word is replaced with ID, so its incoming
    // value is intentionally discarded.
    logic            w_tx_src_unused;
    assign w_tx_src_unused = ^tx_data[BITS-9:BITS-16];

    // Wrap-bit pointer scheme: equal pointers mean empty, equal indices with
    // differing wrap bits mean full.
    assign w_tx_empty = (tx_wr_ptr_q == tx_rd_ptr_q);
    assign w_tx_full  = (tx_wr_ptr_q[c_AW] != tx_rd_ptr_q[c_AW]) &&
                        (tx_wr_ptr_q[c_AW-1:0] == tx_rd_ptr_q[c_AW-1:0]);

    assign w_rx_empty = (rx_wr_ptr_q == rx_rd_ptr_q);
    assign w_rx_full  = (rx_wr_ptr_q[c_AW] != rx_rd_ptr_q[c_AW]) &&
                        (rx_wr_ptr_q[c_AW-1:0] == rx_rd_ptr_q[c_AW-1:0]);

    // Full is taken from the pre-edge state: a same-cycle pop does not free
    // a slot for a write in that cycle.
    assign w_tx_wr_en = tx_valid && !w_tx_full;
    assign w_tx_rd_en = pop && !w_tx_empty;
    assign w_tx_word  = {tx_data[BITS-1:BITS-8], ID, tx_data[BITS-17:0]};

    assign w_rx_addr  = D_push[BITS-1:BITS-8];
    assign w_rx_hit   = (w_rx_addr == ID) || (w_rx_addr == BROADCAST);
    assign w_rx_wr_en = push && w_rx_hit && !w_rx_full;
    assign w_rx_ovf   = push && w_rx_hit &&  w_rx_full;
    assign w_rx_miss  = push && !w_rx_hit;
    assign w_rx_rd_en = rx_ready && !w_rx_empty;

    // ------------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------------
    always_comb begin
        tx_wr_ptr_d     = tx_wr_ptr_q;
        tx_rd_ptr_d     = tx_rd_ptr_q;
        rx_wr_ptr_d     = rx_wr_ptr_q;
        rx_rd_ptr_d     = rx_rd_ptr_q;
        rx_miss_cnt_d   = rx_miss_cnt_q;
        rx_ovf_cnt_d    = rx_ovf_cnt_q;
        err_pop_empty_d = err_pop_empty_q;

        if (w_tx_wr_en) begin
            tx_wr_ptr_d = tx_wr_ptr_q + c_PTR_ONE;
        end
        if (w_tx_rd_en) begin
            tx_rd_ptr_d = tx_rd_ptr_q + c_PTR_ONE;
        end
        if (pop && w_tx_empty) begin
            err_pop_empty_d = 1'b1;
        end

        if (w_rx_wr_en) begin
            rx_wr_ptr_d = rx_wr_ptr_q + c_PTR_ONE;
        end
        if (w_rx_rd_en) begin
            rx_rd_ptr_d = rx_rd_ptr_q + c_PTR_ONE;
        end
        if (w_rx_miss && (rx_miss_cnt_q != c_CNT_MAX)) begin
            rx_miss_cnt_d = rx_miss_cnt_q + 16'd1;
        end
        if (w_rx_ovf && (rx_ovf_cnt_q != c_CNT_MAX)) begin
            rx_ovf_cnt_d = rx_ovf_cnt_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_wr_ptr_q     <= '0;
            tx_rd_ptr_q     <= '0;
            rx_wr_ptr_q     <= '0;
            rx_rd_ptr_q     <= '0;
            rx_miss_cnt_q   <= '0;
            rx_ovf_cnt_q    <= '0;
            err_pop_empty_q <= 1'b0;
        end else begin
            tx_wr_ptr_q     <= tx_wr_ptr_d;
            tx_rd_ptr_q     <= tx_rd_ptr_d;
            rx_wr_ptr_q     <= rx_wr_ptr_d;
            rx_rd_ptr_q     <= rx_rd_ptr_d;
            rx_miss_cnt_q   <= rx_miss_cnt_d;
            rx_ovf_cnt_q    <= rx_ovf_cnt_d;
            err_pop_empty_q <= err_pop_empty_d;
        end
    end

    // ------------------------------------------------------------------------
    // Storage arrays: not reset. Stale contents are never visible because the
    // read data is forced to zero whenever the FIFO is empty.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_tx_wr_en) begin
            tx_mem_q[tx_wr_ptr_q[c_AW-1:0]] <= w_tx_word;
        end
        if (w_rx_wr_en) begin
            rx_mem_q[rx_wr_ptr_q[c_AW-1:0]] <= D_push;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: all derived from registered state only, so there is no
    // combinational path from pop/rx_ready to the head data.
    // ------------------------------------------------------------------------
    assign tx_ready      = !w_tx_full;
    assign tx_count      = tx_wr_ptr_q - tx_rd_ptr_q;
    assign pndng         = !w_tx_empty;
    assign D_pop         = w_tx_empty ? '0 : tx_mem_q[tx_rd_ptr_q[c_AW-1:0]];

    assign rx_valid      = !w_rx_empty;
    assign rx_data       = w_rx_empty ? '0 : rx_mem_q[rx_rd_ptr_q[c_AW-1:0]];
    assign rx_count      = rx_wr_ptr_q - rx_rd_ptr_q;

    assign rx_miss_cnt   = rx_miss_cnt_q;
    assign rx_ovf_cnt    = rx_ovf_cnt_q;
    assign err_pop_empty = err_pop_empty_q;

endmodule
`default_nettype wire

// File: tb/tb_prll_bs_terminal_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_prll_bs_terminal_fifo
// Purpose  : Self-checking bench for prll_bs_terminal_fifo. A queue-based
//            model tracks TX/RX contents and status; every cycle the DUT
//            outputs are compared against it, and directed vectors carry
//            hand-computed expectations that pin the model.
// Revision : 1.0  initial release
// ============================================================================
module tb_prll_bs_terminal_fifo;

    localparam int         BITS      = 32;
    localparam int         DEPTH     = 16;
    localparam logic [7:0] ID        = 8'h00;
    localparam logic [7:0] BROADCAST = 8'hFF;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tx_valid = 1'b0;
    logic [31:0] tx_data = '0;
    logic        tx_ready;
    logic [4:0]  tx_count;
    logic        pndng;
    logic [31:0] D_pop;
    logic        pop = 1'b0;
    logic        push = 1'b0;
    logic [31:0] D_push = '0;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        rx_ready = 1'b0;
    logic [4:0]  rx_count;
    logic [15:0] rx_miss_cnt;
    logic [15:0] rx_ovf_cnt;
    logic        err_pop_empty;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    prll_bs_terminal_fifo #(
        .BITS      (BITS),
        .DEPTH     (DEPTH),
        .ID        (ID),
        .BROADCAST (BROADCAST)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .tx_count      (tx_count),
        .pndng         (pndng),
        .D_pop         (D_pop),
        .pop           (pop),
        .push          (push),
        .D_push        (D_push),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready),
        .rx_count      (rx_count),
        .rx_miss_cnt   (rx_miss_cnt),
        .rx_ovf_cnt    (rx_ovf_cnt),
        .err_pop_empty (err_pop_empty)
    );

    // ------------------------------------------------------------------------
    // Reference model: plain queues and counters
    // ------------------------------------------------------------------------
    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    int          m_miss;
    int          m_ovf;
    bit          m_err;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            txq.delete();
            rxq.delete();
            m_miss = 0;
            m_ovf  = 0;
            m_err  = 1'b0;
        end else begin
            bit tx_was_full;
            bit rx_was_full;
            bit hit;
            tx_was_full = (txq.size() == DEPTH);
            rx_was_full = (rxq.size() == DEPTH);
            // TX
            if (pop) begin
                if (txq.size() > 0) void'(txq.pop_front());
                else                m_err = 1'b1;
            end
            if (tx_valid && !tx_was_full)
                txq.push_back({tx_data[31:24], ID, tx_data[15:0]});
            // RX
            if (rx_ready && rxq.size() > 0) void'(rxq.pop_front());
            if (push) begin
                hit = (D_push[31:24] == ID) || (D_push[31:24] == BROADCAST);
                if (!hit)             begin if (m_miss < 65535) m_miss++; end
                else if (rx_was_full) begin if (m_ovf  < 65535) m_ovf++;  end
                else                  rxq.push_back(D_push);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m.pndng",    32'(pndng),        32'(txq.size() != 0));
            chk("m.D_pop",    D_pop,             (txq.size() != 0) ? txq[0] : 32'h0);
            chk("m.tx_ready", 32'(tx_ready),     32'(txq.size() < DEPTH));
            chk("m.tx_count", 32'(tx_count),     32'(txq.size()));
            chk("m.rx_valid", 32'(rx_valid),     32'(rxq.size() != 0));
            chk("m.rx_data",  rx_data,           (rxq.size() != 0) ? rxq[0] : 32'h0);
            chk("m.rx_count", 32'(rx_count),     32'(rxq.size()));
            chk("m.miss",     32'(rx_miss_cnt),  32'(m_miss));
            chk("m.ovf",      32'(rx_ovf_cnt),   32'(m_ovf));
            chk("m.err",      32'(err_pop_empty), 32'(m_err));
        end
    end

    // Inputs change 1 time unit after the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        // ---------------- 1: reset ----------------
        repeat (3) step();
        reset = 1'b1;
        chk_en = 1'b1;
        step();
        chk("rst.pndng",    32'(pndng),         32'd0);
        chk("rst.D_pop",    D_pop,              32'h0);
        chk("rst.tx_ready", 32'(tx_ready),      32'd1);
        chk("rst.rx_valid", 32'(rx_valid),      32'd0);
        chk("rst.rx_data",  rx_data,            32'h0);
        chk("rst.counts",   {11'd0, tx_count, 11'd0, rx_count}, 32'h0);
        chk("rst.cnts",     {rx_miss_cnt, rx_ovf_cnt}, 32'h0);
        chk("rst.err",      32'(err_pop_empty), 32'd0);

        // ---------------- 2: TX source overwrite, FWFT order ----------------
        tx_valid = 1'b1; tx_data = 32'h01AA0000;
        step();
        chk("t2.D_pop0", D_pop, 32'h01000000);
        chk("t2.pndng",  32'(pndng), 32'd1);
        tx_data = 32'h01AA0001; step();
        tx_data = 32'h01AA0002; step();
        tx_valid = 1'b0;
        pop = 1'b1;
        chk("t2.pop0", D_pop, 32'h01000000); step();
        chk("t2.pop1", D_pop, 32'h01000001); step();
        chk("t2.pop2", D_pop, 32'h01000002); step();
        pop = 1'b0;
        chk("t2.empty", 32'(pndng), 32'd0);

        // ---------------- 3: TX full boundary ----------------
        tx_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            tx_data = 32'h03000000 + 32'(i);
            step();
            if (i == 15) begin
                chk("t3.ready16", 32'(tx_ready), 32'd0);
                chk("t3.count16", 32'(tx_count), 32'd16);
            end
        end
        chk("t3.count17", 32'(tx_count), 32'd16);
        chk("t3.head",    D_pop, 32'h03000000);
        tx_data = 32'h030000AA; pop = 1'b1;
        step();
        tx_valid = 1'b0;
        chk("t3.popwr",   32'(tx_count), 32'd15);
        chk("t3.head2",   D_pop, 32'h03000001);
        repeat (15) step();
        pop = 1'b0;
        chk("t3.drained", 32'(pndng), 32'd0);

        // ---------------- 4: RX address filter ----------------
        push = 1'b1; D_push = 32'h00010005;
        step();
        push = 1'b0;
        chk("t4.valid", 32'(rx_valid), 32'd1);
        chk("t4.data",  rx_data, 32'h00010005);
        push = 1'b1; D_push = 32'h02010006;
        step();
        push = 1'b0;
        chk("t4.miss",  32'(rx_miss_cnt), 32'd1);
        chk("t4.cnt1",  32'(rx_count), 32'd1);
        push = 1'b1; D_push = 32'hFF010007;
        step();
        push = 1'b0;
        chk("t4.bcast", 32'(rx_count), 32'd2);
        rx_ready = 1'b1;
        chk("t4.rd0", rx_data, 32'h00010005); step();
        chk("t4.rd1", rx_data, 32'hFF010007); step();
        step();  // rx_ready on empty RX is a no-op
        rx_ready = 1'b0;
        chk("t4.empty", 32'(rx_count), 32'd0);

        // ---------------- 5: RX overflow ----------------
        push = 1'b1;
        for (int i = 0; i < 17; i++) begin
            D_push = 32'h00001000 + 32'(i);
            step();
        end
        push = 1'b0;
        chk("t5.count", 32'(rx_count), 32'd16);
        chk("t5.ovf",   32'(rx_ovf_cnt), 32'd1);
        chk("t5.head",  rx_data, 32'h00001000);
        // addressed push with same-cycle drain while full is still dropped
        push = 1'b1; D_push = 32'h00002000; rx_ready = 1'b1;
        step();
        push = 1'b0;
        chk("t5.ovf2",  32'(rx_ovf_cnt), 32'd2);
        chk("t5.cnt15", 32'(rx_count), 32'd15);
        chk("t5.head2", rx_data, 32'h00001001);
        repeat (15) step();
        rx_ready = 1'b0;
        chk("t5.drained", 32'(rx_valid), 32'd0);

        // ---------------- all four ops in one cycle ----------------
        tx_valid = 1'b1; tx_data = 32'h04000001; push = 1'b1; D_push = 32'hFF000001; step();
        tx_data = 32'h04000002; D_push = 32'h00000002; step();
        tx_data = 32'h04000003; D_push = 32'h00000003; pop = 1'b1; rx_ready = 1'b1; step();
        tx_valid = 1'b0; push = 1'b0; pop = 1'b0; rx_ready = 1'b0;
        chk("q4.txcnt", 32'(tx_count), 32'd2);
        chk("q4.rxcnt", 32'(rx_count), 32'd2);
        chk("q4.dpop",  D_pop,   32'h04000002);
        chk("q4.rxd",   rx_data, 32'h00000002);

        // ---------------- 6: pop-empty error, mid-traffic reset ----------------
        pop = 1'b1; step(); step();
        chk("t6.noerr", 32'(err_pop_empty), 32'd0);
        step();
        pop = 1'b0;
        chk("t6.err",  32'(err_pop_empty), 32'd1);
        step();
        chk("t6.held", 32'(err_pop_empty), 32'd1);
        tx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_data = 32'h05000000 + 32'(i);
            step();
        end
        tx_valid = 1'b0;
        chk("t6.q5", 32'(tx_count), 32'd5);
        reset = 1'b0;
        #1;
        chk("t6.r.pndng", 32'(pndng), 32'd0);
        chk("t6.r.txcnt", 32'(tx_count), 32'd0);
        chk("t6.r.rxcnt", 32'(rx_count), 32'd0);
        chk("t6.r.err",   32'(err_pop_empty), 32'd0);
        chk("t6.r.dpop",  D_pop, 32'h0);
        chk("t6.r.cnts",  {rx_miss_cnt, rx_ovf_cnt}, 32'h0);
        step(); step();
        reset = 1'b1;
        tx_valid = 1'b1; tx_data = 32'h06AB0001;
        step();
        tx_valid = 1'b0;
        chk("t6.post.cnt", 32'(tx_count), 32'd1);
        chk("t6.post.dat", D_pop, 32'h06000001);
        step();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
`default_nettype wire
